// File: rtl/boot_loader_if.sv
// Command stream, memory write ports and pipeline start-up controls of boot_loader.
// master: the loader (consumes the stream, drives memories and the pipeline).
// slave:  the environment (drives the stream, observes everything else).
interface boot_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_AW    = 10,
  parameter int DMEM_AW    = 10
);
  logic [31:0]           in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [IMEM_AW-1:0]    imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic                  dmem_we;
  logic [DMEM_AW-1:0]    dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  pc_select;
  logic [ADDR_WIDTH-1:0] start_address;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    input  in_data, in_valid,
    output in_ready,
    output imem_we, imem_addr, imem_wdata,
    output dmem_we, dmem_addr, dmem_wdata,
    output pc_select, start_address, busy, done, error
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready,
    input  imem_we, imem_addr, imem_wdata,
    input  dmem_we, dmem_addr, dmem_wdata,
    input  pc_select, start_address, busy, done, error
  );
endinterface

// File: rtl/boot_loader.sv
// Program loader: fills IMEM/DMEM from a 32-bit command stream, then presents
// start_address with pc_select held START_HOLD cycles before releasing the core.
// Latency: one memory write strobe 1 cycle after each accepted payload word.
// Backpressure: in_ready high in IDLE/HDR_ADDR/LOAD only, low during reset.
// Ports: clk, reset (async, active-high); bus (boot_loader_if.master) carries
// the stream, both memory write ports, pc_select/start_address and status.
module boot_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_AW    = 10,
  parameter int DMEM_AW    = 10,
  parameter int START_HOLD = 2
) (
  input  logic            clk,
  input  logic            reset,
  boot_loader_if.master   bus
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("boot_loader: DATA_WIDTH must equal the 32-bit stream width");
  end

  localparam int PW  = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;
  localparam int HW  = $clog2(START_HOLD + 1);
  localparam int IEW = 17 + IMEM_AW;
  localparam int DEW = 17 + DMEM_AW;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [IEW-1:0] IMEM_LIM  = IEW'(1) << IMEM_AW;
  localparam logic [DEW-1:0] DMEM_LIM  = DEW'(1) << DMEM_AW;
  localparam logic [1:0]     CMD_JUMP  = 2'b10;
  localparam logic [1:0]     CMD_ILL   = 2'b11;

  typedef enum logic [2:0] {IDLE, HDR_ADDR, LOAD, START, RUN, ERROR} state_t;

  state_t                state, state_nxt;
  logic [1:0]            cmd_q;
  logic [15:0]           cnt_q;
  logic [PW-1:0]         ptr_q;
  logic [HW-1:0]         hold_q;
  logic                  imem_we_q, dmem_we_q;
  logic [IMEM_AW-1:0]    imem_addr_q;
  logic [DMEM_AW-1:0]    dmem_addr_q;
  logic [DATA_WIDTH-1:0] imem_wdata_q, dmem_wdata_q;
  logic [ADDR_WIDTH-1:0] start_q;

  logic                  ready;
  logic                  accept;
  logic [IEW-1:0]        imem_end;
  logic [DEW-1:0]        dmem_end;
  logic                  imem_oob, dmem_oob, oob;

  // Gate with reset so the stream sees no ready while reset is held.
  assign ready  = !reset && (state == IDLE || state == HDR_ADDR || state == LOAD);
  assign accept = bus.in_valid && ready;

  // Segment end computed wide enough that base+count can never wrap; any base
  // bit above the memory's address range is out of bounds by itself.
  assign imem_end = IEW'(bus.in_data[IMEM_AW-1:0]) + IEW'(cnt_q);
  assign dmem_end = DEW'(bus.in_data[DMEM_AW-1:0]) + DEW'(cnt_q);
  assign imem_oob = (|bus.in_data[31:IMEM_AW]) || (imem_end > IMEM_LIM);
  assign dmem_oob = (|bus.in_data[31:DMEM_AW]) || (dmem_end > DMEM_LIM);
  assign oob      = cmd_q[0] ? dmem_oob : imem_oob;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (bus.in_data[31:30] == CMD_ILL) ? ERROR : HDR_ADDR;
      end
      HDR_ADDR: begin
        if (accept) begin
          if (cmd_q == CMD_JUMP) state_nxt = START;
          else if (cnt_q == 16'd0) state_nxt = IDLE;
          else if (oob)           state_nxt = ERROR;
          else                    state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (accept && cnt_q == 16'd1) state_nxt = IDLE;
      end
      START: begin
        if (hold_q == HOLD_LAST) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q        <= '0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      hold_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      start_q      <= '0;
    end else begin
      // Strobes are single-cycle; addr/wdata hold their last value on stalls.
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      hold_q    <= (state == START) ? hold_q + HW'(1) : '0;
      if (accept) begin
        case (state)
          IDLE: begin
            cmd_q <= bus.in_data[31:30];
            cnt_q <= bus.in_data[15:0];
          end
          HDR_ADDR: begin
            ptr_q <= PW'(bus.in_data);
            if (cmd_q == CMD_JUMP) start_q <= ADDR_WIDTH'(bus.in_data);
          end
          LOAD: begin
            if (cmd_q[0]) begin
              dmem_we_q    <= 1'b1;
              dmem_addr_q  <= ptr_q[DMEM_AW-1:0];
              dmem_wdata_q <= bus.in_data;
            end else begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= ptr_q[IMEM_AW-1:0];
              imem_wdata_q <= bus.in_data;
            end
            ptr_q <= ptr_q + PW'(1);
            cnt_q <= cnt_q - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready      = ready;
  assign bus.imem_we       = imem_we_q;
  assign bus.imem_addr     = imem_addr_q;
  assign bus.imem_wdata    = imem_wdata_q;
  assign bus.dmem_we       = dmem_we_q;
  assign bus.dmem_addr     = dmem_addr_q;
  assign bus.dmem_wdata    = dmem_wdata_q;
  assign bus.start_address = start_q;
  // Core is held at start_address everywhere except RUN, including ERROR.
  assign bus.pc_select     = (state != RUN);
  assign bus.busy          = (state == HDR_ADDR) || (state == LOAD) || (state == START);
  assign bus.done          = (state == RUN);
  assign bus.error         = (state == ERROR);

endmodule
